// File: rtl/main_bus_pkg.sv
// main_bus_pkg: shared types, master indices and round-robin pick for the bus arbiter
//   arb_state_t : arbiter FSM states (IDLE, GRANT, TURN)
//   M_PROC/M_DMA: master indices used for gnt bit positions and owner
//   rr_pick     : winner index for a non-zero request vector given the last owner
package main_bus_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, TURN} arb_state_t;

    localparam logic M_PROC = 1'b0;
    localparam logic M_DMA  = 1'b1;

    // A lone requester wins; on a tie the master that did not own the bus last wins.
    function automatic logic rr_pick(input logic [1:0] r, input logic last);
        return (r == 2'b11) ? ~last : r[1];
    endfunction

endpackage

// File: rtl/arb_timer.sv
// arb_timer: saturating grant-length counter with expiry flag
//   clk, resetL : bus clock, asynchronous active-low reset
//   i_load      : start of a grant; counter becomes 1 (the first grant cycle)
//   i_en        : grant in progress; counter advances and expiry is qualified
//   o_expire    : current grant cycle is number LIMIT
module arb_timer #(
    parameter int LIMIT = 15,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic resetL,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    logic [W-1:0] r_cnt;

    // Holds the number of the grant cycle in progress; saturates so it never wraps.
    always_ff @(posedge clk or negedge resetL) begin
        if (!resetL)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= W'(1);
        else if (i_en && r_cnt != W'(LIMIT))
            r_cnt <= r_cnt + W'(1);
    end

    assign o_expire = i_en && (r_cnt == W'(LIMIT));

endmodule

// File: rtl/main_bus_arbiter.sv
// main_bus_arbiter: two-master round-robin bus arbiter with timeout and turnaround
//   clk, resetL : bus clock, asynchronous active-low reset
//   req[1:0]    : level requests (bit0 processor, bit1 DMA)
//   bus_done    : last-beat pulse from the memory side
//   gnt[1:0]    : registered one-hot-or-zero grant
//   bus_start   : registered pulse in the first grant cycle
//   busy        : registered, high while gnt is non-zero
//   owner       : index of the current or most recent grantee
//   timeout_err : registered pulse when a grant is revoked by timeout
module main_bus_arbiter
    import main_bus_pkg::*;
#(
    parameter int TIMEOUT    = 15,
    parameter int TURNAROUND = 1
) (
    input  logic       clk,
    input  logic       resetL,
    input  logic [1:0] req,
    input  logic       bus_done,
    output logic [1:0] gnt,
    output logic       bus_start,
    output logic       busy,
    output logic       owner,
    output logic       timeout_err
);

    arb_state_t r_state, w_state_nx;
    logic [1:0] r_gnt, w_gnt_nx;
    logic [1:0] r_turn, w_turn_nx;
    logic       r_owner, w_owner_nx;
    logic       r_start, w_start_nx;
    logic       r_terr, w_terr_nx;
    logic       r_busy;
    logic       r_armed;
    logic       w_win;
    logic       w_load;
    logic       w_tmr_en;
    logic       w_expire;

    assign w_win    = rr_pick(req, r_owner);
    assign w_tmr_en = (r_state == GRANT);

    arb_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clk      (clk),
        .resetL   (resetL),
        .i_load   (w_load),
        .i_en     (w_tmr_en),
        .o_expire (w_expire)
    );

    // r_armed blocks granting on the first edge after reset release.
    always_ff @(posedge clk or negedge resetL) begin
        if (!resetL) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_turn  <= '0;
            r_owner <= M_DMA;
            r_start <= 1'b0;
            r_terr  <= 1'b0;
            r_busy  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_gnt   <= w_gnt_nx;
            r_turn  <= w_turn_nx;
            r_owner <= w_owner_nx;
            r_start <= w_start_nx;
            r_terr  <= w_terr_nx;
            r_busy  <= |w_gnt_nx;
            r_armed <= 1'b1;
        end
    end

    // In GRANT r_owner is the grantee, so req[r_owner] is its own request line.
    // Exit priority: done, then abandon, then timeout (only timeout flags an error).
    always_comb begin
        w_state_nx = r_state;
        w_gnt_nx   = r_gnt;
        w_turn_nx  = r_turn;
        w_owner_nx = r_owner;
        w_start_nx = 1'b0;
        w_terr_nx  = 1'b0;
        w_load     = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_armed && req != 2'b00) begin
                    w_state_nx = GRANT;
                    w_owner_nx = w_win;
                    w_gnt_nx   = w_win ? 2'b10 : 2'b01;
                    w_start_nx = 1'b1;
                    w_load     = 1'b1;
                end
            end
            GRANT: begin
                if (bus_done || !req[r_owner] || w_expire) begin
                    w_state_nx = TURN;
                    w_gnt_nx   = 2'b00;
                    w_turn_nx  = 2'd1;
                    w_terr_nx  = !bus_done && req[r_owner];
                end
            end
            TURN: begin
                if (r_turn == 2'(TURNAROUND))
                    w_state_nx = IDLE;
                else
                    w_turn_nx = r_turn + 2'd1;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign gnt         = r_gnt;
    assign bus_start   = r_start;
    assign busy        = r_busy;
    assign owner       = r_owner;
    assign timeout_err = r_terr;

endmodule

// File: doc/main_bus_arbiter.md
MAIN_BUS_ARBITER -- requirements
Module: main_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, max cycles a grant is held without bus_done.
REQ-002 SHALL have parameter TURNAROUND, default 1, idle cycles between release and next grant (range 1..3).
REQ-003 SHALL have port clk  input  1  single bus clock; all state updates on rising edge.
REQ-004 SHALL have port resetL  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  2  per-master bus request (bit0 = processor, bit1 = DMA), level, held until grant ends.
REQ-006 SHALL have port bus_done  input  1  single-cycle pulse from memory side: last beat of the current transaction completed.
REQ-007 SHALL have port gnt  output  2  one-hot-or-zero grant to the masters.
REQ-008 SHALL have port bus_start  output  1  one-cycle pulse in the first cycle gnt is asserted.
REQ-009 SHALL have port busy  output  1  high whenever gnt is non-zero.
REQ-010 SHALL have port owner  output  1  index of the current or most recent grantee.
REQ-011 SHALL have port timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-012 SHALL implement FSM states IDLE, GRANT, TURN; GRANT is the only state with gnt non-zero.
REQ-013 IDLE: when req != 0, SHALL pick a winner and enter GRANT next edge; gnt visible exactly 1 cycle after req is sampled high.
REQ-014 Arbitration SHALL be round-robin: single requester wins; both requesting -> the master that is not owner wins.
REQ-015 GRANT: gnt SHALL stay constant; a new req from the other master SHALL NOT preempt.
REQ-016 GRANT exit on bus_done=1 -> TURN; owner updated to grantee; no error.
REQ-017 GRANT exit when grantee deasserts req before bus_done -> TURN (abandon), no error.
REQ-018 Timeout counter SHALL clear on GRANT entry, increment each GRANT cycle; count == TIMEOUT without bus_done -> TURN and timeout_err pulse in the TURN entry cycle.
REQ-019 bus_done and timeout in the same cycle: done wins, timeout_err SHALL stay low.
REQ-020 TURN SHALL last TURNAROUND cycles with gnt=0, then IDLE; req sampled in TURN are not lost (still level).
REQ-021 bus_done in IDLE or TURN SHALL be ignored.
REQ-022 Counter width SHALL be $clog2(TIMEOUT+1) bits; no wrap in GRANT.
REQ-023 gnt, bus_start, busy, timeout_err SHALL be registered outputs (no combinational path from inputs).

Reset
REQ-024 resetL low SHALL asynchronously force state=IDLE, gnt=0, bus_start=0, busy=0, owner=1 (so processor wins first tie), timeout_err=0, counters=0.
REQ-025 Reset asserted mid-GRANT SHALL drop gnt immediately; no timeout_err generated.
REQ-026 After resetL rises, first grant SHALL occur no earlier than the second rising edge.

Structure
REQ-027 State enum arb_state_t and master index constants (M_PROC=0, M_DMA=1) SHALL live in shared package main_bus_pkg.
REQ-028 Timeout counter MAY be a sub-module arb_timer (load/enable/expire); otherwise single module.

Verification
REQ-029 Only req=01, bus_done 5 cycles after gnt -> gnt=01 one cycle after req, bus_start 1 cycle, gnt=00 cycle after done, TURN 1 cycle.
REQ-030 req=11 from reset -> gnt=01 first; after bus_done, TURN, then gnt=10; after its done, gnt=01 again (alternation).
REQ-031 req=10, no bus_done -> gnt=10 held 15 cycles, then gnt=00 and timeout_err=1 for one cycle.
REQ-032 bus_done on the 15th GRANT cycle -> normal release, timeout_err stays 0.
REQ-033 Grantee drops req mid-GRANT -> gnt=00 next edge, no timeout_err; other pending req granted after TURN.
REQ-034 resetL pulsed low mid-GRANT -> gnt=00 asynchronously, owner=1, next req=11 grants processor.
